// File: rtl/tff_toggle_debounce_if.sv
// Interface for tff_toggle_debounce.
// Carries the raw button input and the debounced outputs.
//   btn_in    : raw, asynchronous, bouncing push-button level
//   T         : single-cycle toggle pulse per accepted press
//   btn_level : debounced button level
//   press_cnt : wrapping count of accepted presses
// The master modport is the side that drives the button and observes results.
// The slave modport is the debouncer itself.
interface tff_toggle_debounce_if #(
    parameter int CNT_W = 8
);
    logic             btn_in;
    logic             T;
    logic             btn_level;
    logic [CNT_W-1:0] press_cnt;

    modport master (output btn_in, input  T, btn_level, press_cnt);
    modport slave  (input  btn_in, output T, btn_level, press_cnt);
endinterface

// File: rtl/tff_toggle_debounce.sv
// tff_toggle_debounce
// This block turns a raw, bouncing push-button into clean toggle pulses for a downstream toggle flip-flop.
// The button is first passed through a 2-flop synchronizer.
// A 4-state FSM then debounces it and emits one registered, single-cycle T pulse per accepted press.
// Releases and bounces never produce a pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of tff_toggle_debounce_if (btn_in in; T, btn_level, press_cnt out)
module tff_toggle_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    tff_toggle_debounce_if.slave  bus
);
    localparam int            DW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, PRESSED, DISARM} state_t;

    state_t           state, state_nx;
    logic [DW-1:0]    dcnt, dcnt_nx;
    logic             sync1, sync2;
    logic             t_q, t_nx;
    logic             lvl_q, lvl_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
            dcnt  <= '0;
            t_q   <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
            state <= state_nx;
            dcnt  <= dcnt_nx;
            t_q   <= t_nx;
            lvl_q <= lvl_nx;
            cnt_q <= cnt_nx;
        end
    end

    // The debounce counter restarts from 0 on every state change.
    // Because of this, a level is accepted only after DEBOUNCE_CYCLES stable samples beyond the one that left the previous state.
    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        t_nx     = 1'b0;
        lvl_nx   = lvl_q;
        cnt_nx   = cnt_q;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_nx = ARM;
                    dcnt_nx  = '0;
                end
            end
            ARM: begin
                if (!sync2) begin
                    state_nx = IDLE;
                    dcnt_nx  = '0;
                end else if (dcnt == DLAST) begin
                    state_nx = PRESSED;
                    dcnt_nx  = '0;
                    t_nx     = 1'b1;
                    lvl_nx   = 1'b1;
                    cnt_nx   = cnt_q + CNT_W'(1);
                end else begin
                    dcnt_nx  = dcnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_nx = DISARM;
                    dcnt_nx  = '0;
                end
            end
            DISARM: begin
                // A return to high here is release bounce, so the FSM goes back to PRESSED without a pulse.
                if (sync2) begin
                    state_nx = PRESSED;
                    dcnt_nx  = '0;
                end else if (dcnt == DLAST) begin
                    state_nx = IDLE;
                    dcnt_nx  = '0;
                    lvl_nx   = 1'b0;
                end else begin
                    dcnt_nx  = dcnt + DW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                dcnt_nx  = '0;
            end
        endcase
    end

    assign bus.T         = t_q;
    assign bus.btn_level = lvl_q;
    assign bus.press_cnt = cnt_q;
endmodule
